// File: rtl/pipe_skid_buf.sv
// Elastic pipeline register: DEPTH-entry FIFO with valid/ready on both sides, synchronous flush
// and an occupancy count. All outputs come from registered state, so out_ready never reaches in_ready.
module pipe_skid_buf #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter bit CLEAR_DATA = 1'b1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_live;
    logic             w_push;
    logic             w_pop;

    // Wrap by explicit compare so non-power-of-two depths index only valid entries.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // r_live holds in_ready low from reset assertion until the first edge after release.
    assign in_ready  = r_live & ~reset & (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign out_data  = (CLEAR_DATA && !out_valid) ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_live   <= 1'b0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
                if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // NOTE: the payload array has no reset; out_valid and the empty-masking of out_data hide stale entries.
    always_ff @(posedge ph1) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= in_data;
    end
endmodule
